// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result buffer slice.
//   - UNIT_* : 2-bit source tags attached to every buffered result
//   - DATA_WIDTH_DEF : default result width of the execution units
//   - UNIT_ID_W : width of the source tag
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 17;
    localparam int UNIT_ID_W      = 2;

    localparam logic [UNIT_ID_W-1:0] UNIT_ARITH = 2'b00;
    localparam logic [UNIT_ID_W-1:0] UNIT_LOGIC = 2'b01;
    localparam logic [UNIT_ID_W-1:0] UNIT_CMP   = 2'b10;
    localparam logic [UNIT_ID_W-1:0] UNIT_SHIFT = 2'b11;

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// First-word-fall-through synchronous FIFO. The head entry is always visible
// on rdata_o (no read latency); pop_i retires it at the next rising edge.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset (clears pointers
//                      and count, storage contents are left as-is)
//   push_i, wdata_i  : write request and data
//   pop_i            : retire the head entry
//   rdata_o          : head entry (undefined content when empty)
//   count_o          : number of stored entries, 0..DEPTH
//   full_o, empty_o  : count == DEPTH / count == 0
// A push while full is only honoured when a pop happens in the same cycle;
// a pop while empty is ignored.
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH      = 19,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are ADDR_WIDTH wide, so the increment wraps modulo DEPTH.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a push in the reset cycle is discarded anyway.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Collects the registered result of whichever ALU unit (arith, logic, compare,
// shift) flags valid this cycle, tags it with a unit ID and queues it in a
// FWFT FIFO drained through a valid/ready handshake.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   <Unit>_OUT, <Unit>_Flag  : unit result and its valid flag
//   OUT_READY                : consumer accepts the head entry
//   ALU_OUT, Unit_ID         : head entry data/source (0 / 00 when empty)
//   OUT_VALID                : FIFO non-empty
//   FIFO_FULL, Count         : occupancy
//   Overflow_Err             : sticky, a result was dropped because full
//   Multi_Flag_Err           : sticky, several unit flags were high at once
//
// Handshake: an entry transfers on a rising edge where OUT_VALID && OUT_READY.
// OUT_VALID and the head data depend only on registered state, never on
// OUT_READY, and the head holds unchanged while OUT_VALID is high and
// OUT_READY is low.
// -----------------------------------------------------------------------------
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] Arith_OUT,
    input  logic                  Arith_Flag,
    input  logic [DATA_WIDTH-1:0] Logic_OUT,
    input  logic                  Logic_Flag,
    input  logic [DATA_WIDTH-1:0] CMP_OUT,
    input  logic                  CMP_Flag,
    input  logic [DATA_WIDTH-1:0] Shift_OUT,
    input  logic                  Shift_Flag,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] ALU_OUT,
    output logic [1:0]            Unit_ID,
    output logic                  OUT_VALID,
    output logic                  FIFO_FULL,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow_Err,
    output logic                  Multi_Flag_Err
);

    localparam int ENTRY_W = DATA_WIDTH + UNIT_ID_W;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [UNIT_ID_W-1:0]  sel_id;
    logic                  push_req;
    logic                  multi_flag;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head;
    logic                  overflow_err_q, overflow_err_d;
    logic                  multi_flag_err_q, multi_flag_err_d;

    // Fixed priority Arith > Logic > CMP > Shift.
    always_comb begin
        sel_data = '0;
        sel_id   = UNIT_ARITH;
        if (Arith_Flag) begin
            sel_data = Arith_OUT;
            sel_id   = UNIT_ARITH;
        end else if (Logic_Flag) begin
            sel_data = Logic_OUT;
            sel_id   = UNIT_LOGIC;
        end else if (CMP_Flag) begin
            sel_data = CMP_OUT;
            sel_id   = UNIT_CMP;
        end else if (Shift_Flag) begin
            sel_data = Shift_OUT;
            sel_id   = UNIT_SHIFT;
        end
    end

    assign push_req   = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
    // Any pair of flags high together.
    assign multi_flag = (Arith_Flag & (Logic_Flag | CMP_Flag | Shift_Flag)) |
                        (Logic_Flag & (CMP_Flag | Shift_Flag)) |
                        (CMP_Flag & Shift_Flag);

    assign pop  = OUT_VALID && OUT_READY;
    // Full FIFO still accepts when the head leaves in the same cycle.
    assign push = push_req && (!fifo_full || pop);
    assign drop = push_req && fifo_full && !pop;

    sync_fifo_fwft #(
        .WIDTH      (ENTRY_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .wdata_i ({sel_id, sel_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (Count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        overflow_err_d   = overflow_err_q | drop;
        multi_flag_err_d = multi_flag_err_q | multi_flag;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_err_q   <= 1'b0;
            multi_flag_err_q <= 1'b0;
        end else begin
            overflow_err_q   <= overflow_err_d;
            multi_flag_err_q <= multi_flag_err_d;
        end
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign OUT_VALID      = !fifo_empty;
    assign FIFO_FULL      = fifo_full;
    assign ALU_OUT        = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign Unit_ID        = fifo_empty ? UNIT_ARITH : head[ENTRY_W-1:DATA_WIDTH];
    assign Overflow_Err   = overflow_err_q;
    assign Multi_Flag_Err = multi_flag_err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

    localparam int DW = 17;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
    logic          Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] ALU_OUT;
    logic [1:0]    Unit_ID;
    logic          OUT_VALID, FIFO_FULL, Overflow_Err, Multi_Flag_Err;
    logic [2:0]    Count;

    always #5 CLK = ~CLK;

    alu_result_buffer dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .OUT_READY(OUT_READY),
        .ALU_OUT(ALU_OUT), .Unit_ID(Unit_ID), .OUT_VALID(OUT_VALID),
        .FIFO_FULL(FIFO_FULL), .Count(Count),
        .Overflow_Err(Overflow_Err), .Multi_Flag_Err(Multi_Flag_Err)
    );

    // ---------------- vector table ----------------
    // flg = {Arith, Logic, CMP, Shift}; expectations are the state after the edge.
    typedef struct {
        logic          rst;
        logic [3:0]    flg;
        logic [DW-1:0] a, l, c, s;
        logic          rdy;
        logic          e_v;
        logic [DW-1:0] e_out;
        logic [1:0]    e_id;
        logic [2:0]    e_cnt;
        logic          e_full, e_ovf, e_mul;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [1:0]    exp_id_q[$];

    task automatic add(input logic rst, input logic [3:0] flg,
                       input logic [DW-1:0] a, l, c, s, input logic rdy,
                       input logic e_v, input logic [DW-1:0] e_out, input logic [1:0] e_id,
                       input logic [2:0] e_cnt, input logic e_full, e_ovf, e_mul);
        vec_t v;
        v.rst = rst; v.flg = flg; v.a = a; v.l = l; v.c = c; v.s = s; v.rdy = rdy;
        v.e_v = e_v; v.e_out = e_out; v.e_id = e_id; v.e_cnt = e_cnt;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_mul = e_mul;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [3:0] flg,
                         input logic [DW-1:0] a, l, c, s, input logic rdy);
        RST = rst;
        Arith_Flag = flg[3]; Logic_Flag = flg[2]; CMP_Flag = flg[1]; Shift_Flag = flg[0];
        Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s;
        OUT_READY = rdy;
    endtask

    initial begin
        // 1. reset then idle
        add(1, 4'b0000, 0, 0, 0, 0, 0,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);
        add(1, 4'b0000, 0, 0, 0, 0, 0,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);
        // 2. single shift result, popped next cycle
        add(0, 4'b0001, 0, 0, 0, 17'h0A5A4, 1, 1, 17'h0A5A4, 2'd3, 3'd1, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);
        // 3. fill with consumer stalled, overflow, then drain
        add(0, 4'b1000, 1, 0, 0, 0, 0,   1, 17'd1,     2'd0, 3'd1, 0, 0, 0);
        add(0, 4'b0100, 0, 2, 0, 0, 0,   1, 17'd1,     2'd0, 3'd2, 0, 0, 0);
        add(0, 4'b0010, 0, 0, 3, 0, 0,   1, 17'd1,     2'd0, 3'd3, 0, 0, 0);
        add(0, 4'b0001, 0, 0, 0, 4, 0,   1, 17'd1,     2'd0, 3'd4, 1, 0, 0);
        add(0, 4'b0001, 0, 0, 0, 5, 0,   1, 17'd1,     2'd0, 3'd4, 1, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   1, 17'd2,     2'd1, 3'd3, 0, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   1, 17'd3,     2'd2, 3'd2, 0, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   1, 17'd4,     2'd3, 3'd1, 0, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   0, 17'h0,     2'd0, 3'd0, 0, 1, 0);
        // 4. full with simultaneous push and pop
        add(1, 4'b0000, 0, 0, 0, 0, 0,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);
        add(0, 4'b1000, 1, 0, 0, 0, 0,   1, 17'd1,     2'd0, 3'd1, 0, 0, 0);
        add(0, 4'b0100, 0, 2, 0, 0, 0,   1, 17'd1,     2'd0, 3'd2, 0, 0, 0);
        add(0, 4'b0010, 0, 0, 3, 0, 0,   1, 17'd1,     2'd0, 3'd3, 0, 0, 0);
        add(0, 4'b0001, 0, 0, 0, 4, 0,   1, 17'd1,     2'd0, 3'd4, 1, 0, 0);
        add(0, 4'b1000, 9, 0, 0, 0, 1,   1, 17'd2,     2'd1, 3'd4, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   1, 17'd3,     2'd2, 3'd3, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   1, 17'd4,     2'd3, 3'd2, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   1, 17'd9,     2'd0, 3'd1, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);
        // 5. multi-flag: logic wins over shift, error is sticky
        add(0, 4'b0101, 0, 7, 0, 8, 0,   1, 17'd7,     2'd1, 3'd1, 0, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 0,   1, 17'd7,     2'd1, 3'd1, 0, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   0, 17'h0,     2'd0, 3'd0, 0, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   0, 17'h0,     2'd0, 3'd0, 0, 0, 1);
        // 6. reset mid-operation dominates push and pop
        add(0, 4'b1000, 17'h11, 0, 0, 0, 0, 1, 17'h11, 2'd0, 3'd1, 0, 0, 1);
        add(0, 4'b0010, 0, 0, 17'h22, 0, 0, 1, 17'h11, 2'd0, 3'd2, 0, 0, 1);
        add(0, 4'b0001, 0, 0, 0, 17'h33, 0, 1, 17'h11, 2'd0, 3'd3, 0, 0, 1);
        add(1, 4'b1000, 17'h44, 0, 0, 0, 1, 0, 17'h0, 2'd0, 3'd0, 0, 0, 0);
        add(0, 4'b0001, 0, 0, 0, 17'h1FFFF, 0, 1, 17'h1FFFF, 2'd3, 3'd1, 0, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 1,   0, 17'h0,     2'd0, 3'd0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flg, vecs[i].a, vecs[i].l, vecs[i].c, vecs[i].s, vecs[i].rdy);
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d OUT_VALID", i),      32'(OUT_VALID),      32'(vecs[i].e_v));
            chk($sformatf("v%0d ALU_OUT", i),        32'(ALU_OUT),        32'(vecs[i].e_out));
            chk($sformatf("v%0d Unit_ID", i),        32'(Unit_ID),        32'(vecs[i].e_id));
            chk($sformatf("v%0d Count", i),          32'(Count),          32'(vecs[i].e_cnt));
            chk($sformatf("v%0d FIFO_FULL", i),      32'(FIFO_FULL),      32'(vecs[i].e_full));
            chk($sformatf("v%0d Overflow_Err", i),   32'(Overflow_Err),   32'(vecs[i].e_ovf));
            chk($sformatf("v%0d Multi_Flag_Err", i), 32'(Multi_Flag_Err), 32'(vecs[i].e_mul));
        end

        // ---------------- streaming sequence with scoreboard ----------------
        // One push per cycle while the consumer stalls every third cycle;
        // an own occupancy model decides acceptance, exp_q tracks order.
        begin
            int m_cnt;
            int cyc;
            logic m_pop, m_push;
            logic [DW-1:0] val;
            logic [3:0] flg;
            m_cnt = 0;
            for (int i = 0; i < 12; i++) begin
                flg = (i < 9) ? (4'b1000 >> (i % 4)) : 4'b0000;
                val = 17'(17'h100 + i * 17'h35);
                drive(0, flg, val, val, val, val, (i % 3) != 2);
                chk($sformatf("s%0d Count", i), 32'(Count), 32'(m_cnt));
                m_pop = (m_cnt > 0) && OUT_READY;
                if (m_cnt > 0) begin
                    chk($sformatf("s%0d ALU_OUT", i), 32'(ALU_OUT), 32'(exp_q[0]));
                    chk($sformatf("s%0d Unit_ID", i), 32'(Unit_ID), 32'(exp_id_q[0]));
                end
                m_push = (flg != 0) && (m_cnt < 4 || m_pop);
                if (m_pop) begin
                    void'(exp_q.pop_front());
                    void'(exp_id_q.pop_front());
                    m_cnt--;
                end
                if (m_push) begin
                    exp_q.push_back(val);
                    exp_id_q.push_back(2'(i % 4));
                    m_cnt++;
                end
                @(posedge CLK);
                #1;
            end
            // Bounded drain of whatever remains.
            cyc = 0;
            drive(0, 4'b0000, 0, 0, 0, 0, 1);
            while (exp_q.size() > 0 && cyc < 20) begin
                chk($sformatf("d%0d OUT_VALID", cyc), 32'(OUT_VALID), 32'd1);
                chk($sformatf("d%0d ALU_OUT", cyc), 32'(ALU_OUT), 32'(exp_q[0]));
                chk($sformatf("d%0d Unit_ID", cyc), 32'(Unit_ID), 32'(exp_id_q[0]));
                void'(exp_q.pop_front());
                void'(exp_id_q.pop_front());
                @(posedge CLK);
                #1;
                cyc++;
            end
            chk("drain bound", 32'(exp_q.size()), 32'd0);
            chk("drained OUT_VALID", 32'(OUT_VALID), 32'd0);
            chk("drained Overflow_Err", 32'(Overflow_Err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
